// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types for the instruction fetch stage: word type, FIFO entry layout,
// ARM word size and the wait-state FSM encoding.
package fetch_prefetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam int unsigned ARM_INSTR_BYTES = 4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_t;

  // Next sequential instruction address; wraps naturally at 2^32.
  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(ARM_INSTR_BYTES);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Simple memory bus between a master (fetch) and the memory slave (MMU).
interface Bus_if;
  import fetch_prefetch_unit_pkg::*;

  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  read_en;
  logic  write_en;

  modport Master_side (
    output addr,
    output wdata,
    output read_en,
    output write_en,
    input  rdata
  );

  modport Slave_side (
    input  addr,
    input  wdata,
    input  read_en,
    input  write_en,
    output rdata
  );
endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries. Clear wins over push
// and pop; push while full is accepted only when a pop frees the slot in the
// same cycle. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module fetch_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_eff, pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];

  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  // Occupancy bookkeeping: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; clear discards everything in one cycle.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_eff)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_eff && !clear_i && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: streams sequential ARM words from fetch_pc into a
// prefetch FIFO and hands {pc, instr} to decode over valid/ready.
// Optional build macro FETCH_WAITSTATE_EN adds a WAIT state that holds each
// read for WAIT_CYCLES extra bus cycles; without it every read is zero-wait.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter word_t       RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset,
  Bus_if.Master_side bus,
  input  logic   bus_grant,
  input  logic   flush,
  input  word_t  flush_addr,
  output logic   out_valid,
  input  logic   out_ready,
  output word_t  out_instr,
  output word_t  out_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  word_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          pop_req, slot_ok, issue;
  logic          read_en, capture;
  fetch_entry_t  push_entry, head_entry;

  assign out_valid = ~fifo_empty;
  assign out_instr = head_entry.instr;
  assign out_pc    = head_entry.pc;
  assign pop_req   = out_valid & out_ready;

  // A new read may start if a slot is free now or is being freed by a pop.
  assign slot_ok = (count < CW'(DEPTH)) | pop_req;
  assign issue   = ~reset & bus_grant & ~flush & slot_ok;

  assign bus.addr     = fetch_pc_q;
  assign bus.read_en  = read_en;
  assign bus.write_en = 1'b0;
  assign bus.wdata    = '0;

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = bus.rdata;

`ifdef FETCH_WAITSTATE_EN
  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  fetch_state_t   state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           wait_live, wait_last;

  // In WAIT the read stays up only while granted and not flushed.
  assign wait_live = ~reset & bus_grant & ~flush;
  assign wait_last = (int'(wait_cnt_q) == int'(WAIT_CYCLES) - 1);

  // Bus request and capture strobe derived from the current FSM state.
  always_comb begin
    read_en = 1'b0;
    capture = 1'b0;
    if (state_q == ST_FETCH) begin
      read_en = issue;
      capture = issue & (WAIT_CYCLES == 0);
    end else begin
      read_en = wait_live;
      capture = wait_live & wait_last;
    end
  end

  // Wait-state FSM: one outstanding read, aborted by grant loss or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          wait_cnt_q <= '0;
          if (issue && (WAIT_CYCLES != 0)) state_q <= ST_WAIT;
        end
        default: begin
          if (!wait_live || wait_last) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^WAIT_CYCLES;

  // Zero-wait: data returns in the request cycle and is pushed at the edge.
  always_comb begin
    read_en = issue;
    capture = issue;
  end
`endif

  // Next fetch address: flush redirect beats sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush)        fetch_pc_d = {flush_addr[31:2], 2'b00};
    else if (capture) fetch_pc_d = next_pc(fetch_pc_q);
  end

  // Fetch address register.
  always_ff @(posedge clk) begin
    if (reset) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  logic unused_misc;
  assign unused_misc = ^{fifo_full, flush_addr[1:0]};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (capture),
    .push_data_i (push_entry),
    .pop_i       (pop_req),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

endmodule
